const_split_unit: RTL and testbench
===================================

CONST_SPLIT_UNIT -- requirements
Module: const_split_unit

Interface
REQ-001 The block SHALL have parameter SKIP_ZERO, default 1: 1 = omit all-zero halfword beats (except as REQ-014), 0 = always emit two beats.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, 32-bit constant offered.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a constant this cycle.
REQ-006 The block SHALL have port in_word, input, 32, constant to decompose.
REQ-007 The block SHALL have port out_valid, output, 1, halfword beat presented.
REQ-008 The block SHALL have port out_ready, input, 1, consumer accepts beat.
REQ-009 The block SHALL have port out_half, output, 16, halfword payload.
REQ-010 The block SHALL have port out_is_lower, output, 1, beat type: 0 = upper halfword (LUI immediate), 1 = lower halfword (ORI immediate).
REQ-011 The block SHALL have port out_last, output, 1, final beat of the current constant.

Function
REQ-012 The block SHALL implement states IDLE, UPPER, LOWER; in_ready SHALL be 1 exactly in IDLE.
REQ-013 In IDLE with in_valid=1, the block SHALL register in_word and transition to UPPER, unless SKIP_ZERO=1 and in_word[31:16]=0, in which case it SHALL transition to LOWER.
REQ-014 When SKIP_ZERO=1 and in_word=0, the block SHALL emit exactly one LOWER beat with out_half=0x0000.
REQ-015 out_valid SHALL be 1 exactly in UPPER and LOWER; the first beat SHALL appear the cycle after acceptance (latency 1).
REQ-016 In UPPER, out_half SHALL be the stored word[31:16] and out_is_lower=0; in LOWER, out_half SHALL be the stored word[15:0] and out_is_lower=1.
REQ-017 A beat SHALL complete only on a cycle with out_valid=1 and out_ready=1.
REQ-018 On completion in UPPER, the block SHALL go to LOWER, unless SKIP_ZERO=1 and stored word[15:0]=0, in which case it SHALL go to IDLE.
REQ-019 On completion in LOWER, the block SHALL go to IDLE.
REQ-020 out_last SHALL be 1 in the state whose completion returns to IDLE, else 0.
REQ-021 While out_valid=1 and out_ready=0, out_half, out_is_lower and out_last SHALL remain stable.
REQ-022 in_word and in_valid SHALL be ignored outside IDLE; no constant is accepted on the cycle the last beat completes (minimum 1 IDLE cycle between constants).
REQ-023 All outputs SHALL be driven from registers or the state register only; no combinational path from in_* or out_ready to out_*.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL enter IDLE with out_valid=0, out_half=0x0000, out_is_lower=0, out_last=0, stored word=0.
REQ-025 in_ready SHALL be 1 in the cycle after reset release.
REQ-026 rst SHALL take priority over all handshakes; reset mid-operation SHALL discard the in-flight constant with no further beats.

Verification
REQ-027 Scenario 1: SKIP_ZERO=1, in_word=0x12345678, out_ready=1 -> beat 0x1234 (is_lower=0, last=0), then beat 0x5678 (is_lower=1, last=1), then in_ready=1.
REQ-028 Scenario 2: in_word=0x00AB0000 -> single beat 0x00AB, is_lower=0, last=1.
REQ-029 Scenario 3: in_word=0x0000BEEF -> single beat 0xBEEF, is_lower=1, last=1; in_word=0x00000000 -> single beat 0x0000, is_lower=1, last=1.
REQ-030 Scenario 4: SKIP_ZERO=0, in_word=0x00000000 -> two beats, 0x0000/is_lower=0/last=0, then 0x0000/is_lower=1/last=1.
REQ-031 Scenario 5: in_word=0xCAFE1234, out_ready=0 for 3 cycles -> 0xCAFE held stable with in_ready=0; a new in_valid with 0xFFFFFFFF is ignored; the sequence completes normally after out_ready=1.
REQ-032 Scenario 6: rst=1 while in UPPER with 0x12345678 -> next cycle out_valid=0, in_ready=1, and no 0x5678 beat ever appears.

Source files
------------

// File: rtl/const_split_unit.sv
// -----------------------------------------------------------------------------
// const_split_unit
//
// Splits a 32-bit constant into the halfword immediates needed to build it
// with a LUI/ORI pair. Each accepted constant produces one or two beats on a
// valid/ready output channel: the upper halfword (LUI immediate) first, then
// the lower halfword (ORI immediate). With SKIP_ZERO set, a beat whose payload
// is all zero is dropped. The one exception is a constant that is entirely
// zero, which still produces a single lower beat of 0x0000 so the consumer
// always sees at least one beat per constant.
//
// Parameters
//   SKIP_ZERO    1 = omit all-zero halfword beats, 0 = always emit two beats
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   in_valid     a 32-bit constant is offered on in_word
//   in_ready     block can accept a constant this cycle (high only when idle)
//   in_word      constant to decompose
//   out_valid    a halfword beat is presented
//   out_ready    consumer accepts the presented beat
//   out_half     halfword payload
//   out_is_lower beat type: 0 = upper halfword, 1 = lower halfword
//   out_last     final beat of the current constant
// -----------------------------------------------------------------------------
module const_split_unit #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_half,
    output logic        out_is_lower,
    output logic        out_last
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_UPPER = 2'd1;
    localparam logic [1:0] ST_LOWER = 2'd2;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] word_q;
    logic [31:0] word_d;

    logic in_upper;
    logic in_lower;
    logic beat_done;
    logic stored_lower_zero;

    assign in_upper  = (state_q == ST_UPPER);
    assign in_lower  = (state_q == ST_LOWER);
    assign beat_done = (in_upper || in_lower) && out_ready;

    // Whether the upper beat of the held constant is also its final beat.
    assign stored_lower_zero = SKIP_ZERO && (word_q[15:0] == 16'h0000);

    // Next-state logic. The word register only loads on acceptance, so while
    // a beat is stalled the outputs derived from it cannot change. An input
    // constant whose upper half is zero goes straight to LOWER when zero
    // skipping is on; that path also covers the all-zero constant, which then
    // emits its single 0x0000 lower beat.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    word_d = in_word;
                    if (SKIP_ZERO && (in_word[31:16] == 16'h0000)) begin
                        state_d = ST_LOWER;
                    end else begin
                        state_d = ST_UPPER;
                    end
                end
            end
            ST_UPPER: begin
                if (beat_done) begin
                    if (stored_lower_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOWER;
                    end
                end
            end
            ST_LOWER: begin
                if (beat_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and stored word. Reset wins over any handshake in flight and
    // discards the held constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    // Outputs are decoded from the state and word registers only, so there is
    // no combinational path from the input channel or out_ready to out_*.
    // The idle payload reads as zero rather than leaking the last constant.
    always_comb begin
        in_ready     = (state_q == ST_IDLE);
        out_valid    = in_upper || in_lower;
        out_is_lower = in_lower;
        out_half     = 16'h0000;
        out_last     = 1'b0;
        if (in_upper) begin
            out_half = word_q[31:16];
            out_last = stored_lower_zero;
        end else if (in_lower) begin
            out_half = word_q[15:0];
            out_last = 1'b1;
        end
    end

endmodule

// File: tb/tb_const_split_unit.sv
// -----------------------------------------------------------------------------
// tb_const_split_unit
//
// Drives two instances side by side: unit 0 with zero skipping, unit 1
// without. A behavioural model turns each accepted constant into its list of
// expected beats and a compare process checks both units against it on every
// cycle. Directed scenarios add hand-computed literal checks on top.
// -----------------------------------------------------------------------------
module tb_const_split_unit;

    typedef struct packed {
        logic [15:0] half;
        logic        is_lower;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid     [2];
    logic [31:0] in_word      [2];
    logic        out_ready    [2];
    logic        in_ready     [2];
    logic        out_valid    [2];
    logic [15:0] out_half     [2];
    logic        out_is_lower [2];
    logic        out_last     [2];

    int nCompared   = 0;
    int nMismatched = 0;
    bit started     = 1'b0;

    beat_t q0[$];
    beat_t q1[$];

    always #5 clk = ~clk;

    const_split_unit #(.SKIP_ZERO(1'b1)) u_skip (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_word(in_word[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_half(out_half[0]),
        .out_is_lower(out_is_lower[0]), .out_last(out_last[0])
    );

    const_split_unit #(.SKIP_ZERO(1'b0)) u_full (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_word(in_word[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_half(out_half[1]),
        .out_is_lower(out_is_lower[1]), .out_last(out_last[1])
    );

    // Beat list for one constant: both halves unless skipping drops a zero
    // half; an all-zero constant still yields a single lower 0x0000 beat.
    function automatic int expand(input logic [31:0] w, input bit skip,
                                  output beat_t b0, output beat_t b1);
        logic [15:0] up;
        logic [15:0] lo;
        up = w[31:16];
        lo = w[15:0];
        b0 = '0;
        b1 = '0;
        if (!skip || (up != 16'h0 && lo != 16'h0)) begin
            b0 = '{up, 1'b0, 1'b0};
            b1 = '{lo, 1'b1, 1'b1};
            return 2;
        end
        if (up != 16'h0) begin
            b0 = '{up, 1'b0, 1'b1};
            return 1;
        end
        b0 = '{lo, 1'b1, 1'b1};
        return 1;
    endfunction

    // Model: an idle unit takes a constant and queues its beats; a busy unit
    // retires the head beat when the consumer is ready.
    always @(posedge clk) begin
        beat_t b0;
        beat_t b1;
        int    n;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (q0.size() == 0) begin
                if (in_valid[0] === 1'b1) begin
                    n = expand(in_word[0], 1'b1, b0, b1);
                    q0.push_back(b0);
                    if (n == 2) q0.push_back(b1);
                end
            end else if (out_ready[0] === 1'b1) begin
                void'(q0.pop_front());
            end
            if (q1.size() == 0) begin
                if (in_valid[1] === 1'b1) begin
                    n = expand(in_word[1], 1'b0, b0, b1);
                    q1.push_back(b0);
                    if (n == 2) q1.push_back(b1);
                end
            end else if (out_ready[1] === 1'b1) begin
                void'(q1.pop_front());
            end
        end
    end

    task automatic compareUnit(input int u);
        beat_t exp;
        bit    busy;
        busy = (u == 0) ? (q0.size() != 0) : (q1.size() != 0);
        exp  = '0;
        if (busy) exp = (u == 0) ? q0[0] : q1[0];
        nCompared++;
        if (in_ready[u] !== !busy || out_valid[u] !== busy) begin
            nMismatched++;
            $display("[TB] FAIL model_handshake unit%0d t=%0t: ready/valid got %b%b want %b%b",
                     u, $time, in_ready[u], out_valid[u], !busy, busy);
        end
        if (busy) begin
            nCompared++;
            if ({out_half[u], out_is_lower[u], out_last[u]} !== exp) begin
                nMismatched++;
                $display("[TB] FAIL model_beat unit%0d t=%0t: half/lower/last got %h/%b/%b want %h/%b/%b",
                         u, $time, out_half[u], out_is_lower[u], out_last[u],
                         exp.half, exp.is_lower, exp.last);
            end
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            compareUnit(0);
            compareUnit(1);
        end
    end

    // Literal check; the payload is only checked when a beat is expected.
    task automatic checkOutput(input int u, input string name, input logic expReady,
                               input logic expValid, input logic [15:0] expHalf,
                               input logic expLower, input logic expLast);
        nCompared++;
        if (expValid) begin
            if ({in_ready[u], out_valid[u], out_half[u], out_is_lower[u], out_last[u]} !==
                {expReady, expValid, expHalf, expLower, expLast}) begin
                nMismatched++;
                $display("[TB] FAIL %s unit%0d: rdy/vld/half/lower/last got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b",
                         name, u, in_ready[u], out_valid[u], out_half[u], out_is_lower[u],
                         out_last[u], expReady, expValid, expHalf, expLower, expLast);
            end
        end else if ({in_ready[u], out_valid[u]} !== {expReady, expValid}) begin
            nMismatched++;
            $display("[TB] FAIL %s unit%0d: rdy/vld got %b/%b want %b/%b",
                     name, u, in_ready[u], out_valid[u], expReady, expValid);
        end
    endtask

    task automatic checkReset(input int u, input string name);
        nCompared++;
        if ({in_ready[u], out_valid[u], out_half[u], out_is_lower[u], out_last[u]} !==
            {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL %s unit%0d: rdy/vld/half/lower/last got %b/%b/%h/%b/%b want 1/0/0000/0/0",
                     name, u, in_ready[u], out_valid[u], out_half[u], out_is_lower[u], out_last[u]);
        end
    endtask

    // Offer one constant on unit u once it is idle; returns at the negedge
    // after the accepting edge, when the first beat should be visible.
    task automatic applyStimulus(input int u, input logic [31:0] w);
        int waited;
        waited = 0;
        while (in_ready[u] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL accept_timeout unit%0d: in_ready got %b want 1", u, in_ready[u]);
            return;
        end
        in_valid[u] = 1'b1;
        in_word[u]  = w;
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_word[u]  = $urandom;
    endtask

    logic [31:0] table_words [8];

    initial begin
        table_words = '{32'h12345678, 32'h00010000, 32'h00000001, 32'hFFFFFFFF,
                        32'h80000000, 32'h0000FFFF, 32'h00000000, 32'hA5A55A5A};
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            in_word[u]   = 32'h0;
            out_ready[u] = 1'b1;
        end
        repeat (2) @(negedge clk);
        started = 1'b1;
        checkReset(0, "reset_state");
        checkReset(1, "reset_state");
        rst = 1'b0;
        @(negedge clk);
        checkOutput(0, "post_reset_ready", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput(1, "post_reset_ready", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Two beats, full handshake
        applyStimulus(0, 32'h12345678);
        checkOutput(0, "s1_upper", 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput(0, "s1_lower", 1'b0, 1'b1, 16'h5678, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput(0, "s1_ready", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Zero lower half skipped
        applyStimulus(0, 32'h00AB0000);
        checkOutput(0, "s2_only", 1'b0, 1'b1, 16'h00AB, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput(0, "s2_ready", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Zero upper half skipped, and the all-zero constant
        applyStimulus(0, 32'h0000BEEF);
        checkOutput(0, "s3_beef", 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput(0, "s3_ready", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(0, 32'h00000000);
        checkOutput(0, "s3_zero", 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput(0, "s3_zero_ready", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // No skipping: zero halves still emitted
        applyStimulus(1, 32'h00000000);
        checkOutput(1, "s4_upper", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput(1, "s4_lower", 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput(1, "s4_ready", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1, 32'h00AB0000);
        checkOutput(1, "s4b_upper", 1'b0, 1'b1, 16'h00AB, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput(1, "s4b_lower", 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);

        // Back-pressure with a competing constant that must be ignored
        out_ready[0] = 1'b0;
        applyStimulus(0, 32'hCAFE1234);
        for (int i = 0; i < 3; i++) begin
            checkOutput(0, "s5_hold", 1'b0, 1'b1, 16'hCAFE, 1'b0, 1'b0);
            in_valid[0] = 1'b1;
            in_word[0]  = 32'hFFFFFFFF;
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        checkOutput(0, "s5_hold_end", 1'b0, 1'b1, 16'hCAFE, 1'b0, 1'b0);
        out_ready[0] = 1'b1;
        @(negedge clk);
        checkOutput(0, "s5_lower", 1'b0, 1'b1, 16'h1234, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput(0, "s5_ready", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput(0, "s5_no_ffff", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Reset while holding the upper beat
        out_ready[0] = 1'b0;
        applyStimulus(0, 32'h12345678);
        checkOutput(0, "s6_upper", 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkReset(0, "s6_after_rst");
        rst = 1'b0;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput(0, "s6_no_beat", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        end

        // Table sweep with irregular back-pressure, checked by the model
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 8; k++) begin
                applyStimulus(u, table_words[k]);
                for (int c = 0; c < 5; c++) begin
                    out_ready[u] = ((k + c) % 3) != 1;
                    @(negedge clk);
                end
                out_ready[u] = 1'b1;
            end
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
